// File: rtl/acl_spi_responder.sv
// SPI mode-0 register responder for an accelerometer front end: ID/part registers,
// snapshotted X/Y/Z axis samples and a single writable power-control register.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | cs deasserted (or not yet seen high since reset); miso held 0
// CMD    | shifting in the command byte
// ADDR   | shifting in the register address byte
// RDATA  | read burst: shifting register bytes out on miso
// WDATA  | write burst: shifting data bytes in, committing to 0x2D only
// IGNORE | unsupported command; everything ignored until cs rises
module acl_spi_responder #(
    parameter logic [7:0] PARTID      = 8'hF2,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs,
    output logic        miso,
    input  logic [11:0] x_data,
    input  logic [11:0] y_data,
    input  logic [11:0] z_data,
    output logic [7:0]  power_ctl,
    output logic        cmd_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_RDATA  = 3'd3;
    localparam logic [2:0] ST_WDATA  = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [5:0] ADDR_PCTL = 6'h2D;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sync_fill;

    logic sclk_s, mosi_s, cs_s;
    logic sclk_q, cs_q, cs_armed;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [2:0]  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_in;
    logic [7:0]  shift_out;
    logic [7:0]  next_in;
    logic [7:0]  rd_data;
    logic [5:0]  addr;
    logic        is_read;
    logic        wr_pend;
    logic [7:0]  wr_byte;
    logic [11:0] x_snap, y_snap, z_snap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sync_fill <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    // cs_armed keeps the reset value of the cs synchronizer from looking like a
    // falling edge when cs is already low at reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_q   <= 1'b0;
            cs_q     <= 1'b1;
            cs_armed <= 1'b0;
        end else begin
            sclk_q   <= sclk_s;
            cs_q     <= cs_s;
            cs_armed <= cs_armed | (sync_fill[SYNC_STAGES-1] & cs_s);
        end
    end

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_fall   = cs_armed & cs_q & ~cs_s;
    assign cs_rise   = cs_s & ~cs_q;
    assign next_in   = {shift_in[6:0], mosi_s};

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            6'h00: rd_data = 8'hAD;
            6'h01: rd_data = 8'h1D;
            6'h02: rd_data = PARTID;
            6'h08: rd_data = x_snap[11:4];
            6'h09: rd_data = y_snap[11:4];
            6'h0A: rd_data = z_snap[11:4];
            6'h0E: rd_data = x_snap[7:0];
            6'h0F: rd_data = {{4{x_snap[11]}}, x_snap[11:8]};
            6'h10: rd_data = y_snap[7:0];
            6'h11: rd_data = {{4{y_snap[11]}}, y_snap[11:8]};
            6'h12: rd_data = z_snap[7:0];
            6'h13: rd_data = {{4{z_snap[11]}}, z_snap[11:8]};
            ADDR_PCTL: rd_data = power_ctl;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shift_in  <= 8'h00;
            shift_out <= 8'h00;
            miso      <= 1'b0;
            cmd_err   <= 1'b0;
            addr      <= 6'h00;
            is_read   <= 1'b0;
            wr_pend   <= 1'b0;
            wr_byte   <= 8'h00;
            power_ctl <= 8'h00;
            x_snap    <= 12'h000;
            y_snap    <= 12'h000;
            z_snap    <= 12'h000;
        end else begin
            cmd_err <= 1'b0;
            wr_pend <= 1'b0;
            if (wr_pend) begin
                power_ctl <= wr_byte;
            end

            // A cs falling edge outside IDLE is a glitch: restart the transaction.
            if (cs_fall) begin
                state    <= ST_CMD;
                bit_cnt  <= 3'd0;
                shift_in <= 8'h00;
                miso     <= 1'b0;
                x_snap   <= x_data;
                y_snap   <= y_data;
                z_snap   <= z_data;
            end else if (cs_rise) begin
                state   <= ST_IDLE;
                bit_cnt <= 3'd0;
                miso    <= 1'b0;
            end else if (sclk_rise && state != ST_IDLE && state != ST_IGNORE) begin
                shift_in <= next_in;
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    case (state)
                        ST_CMD: begin
                            if (next_in == CMD_READ) begin
                                is_read <= 1'b1;
                                state   <= ST_ADDR;
                            end else if (next_in == CMD_WRITE) begin
                                is_read <= 1'b0;
                                state   <= ST_ADDR;
                            end else begin
                                state   <= ST_IGNORE;
                                cmd_err <= 1'b1;
                            end
                        end
                        ST_ADDR: begin
                            addr  <= next_in[5:0];
                            state <= is_read ? ST_RDATA : ST_WDATA;
                        end
                        ST_WDATA: begin
                            wr_pend <= (addr == ADDR_PCTL);
                            wr_byte <= next_in;
                            addr    <= addr + 6'd1;
                        end
                        ST_RDATA: begin
                            addr <= addr + 6'd1;
                        end
                        default: ;
                    endcase
                end
            end else if (sclk_fall && state == ST_RDATA) begin
                // bit_cnt == 0 marks the first falling edge of a new byte.
                if (bit_cnt == 3'd0) begin
                    shift_out <= rd_data;
                    miso      <= rd_data[7];
                end else begin
                    shift_out <= {shift_out[6:0], 1'b0};
                    miso      <= shift_out[6];
                end
            end
        end
    end

endmodule

// File: tb/tb_acl_spi_responder.sv
// Directed bench for acl_spi_responder: a transaction-level register model plus a
// per-cycle monitor on power_ctl and the miso idle level.
module tb_acl_spi_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs = 1'b1;
    logic        miso;
    logic [11:0] x_data = 12'h000;
    logic [11:0] y_data = 12'h000;
    logic [11:0] z_data = 12'h000;
    logic [7:0]  power_ctl;
    logic        cmd_err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cycles = 0;

    logic [7:0]  m_power = 8'h00;
    logic [11:0] s_x = 12'h000, s_y = 12'h000, s_z = 12'h000;
    bit          pc_check = 1'b1;
    bit          miso_zero = 1'b1;
    logic [7:0]  wbuf [16];
    logic [7:0]  rbuf [16];

    always #5 clk = ~clk;

    acl_spi_responder dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs        (cs),
        .miso      (miso),
        .x_data    (x_data),
        .y_data    (y_data),
        .z_data    (z_data),
        .power_ctl (power_ctl),
        .cmd_err   (cmd_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int signed_val(input logic [11:0] v);
        return v[11] ? int'(v) - 4096 : int'(v);
    endfunction

    // Expected register contents from the snapshot of the current transaction.
    function automatic logic [7:0] model_reg(input logic [5:0] a);
        int v;
        case (a)
            6'h00: return 8'hAD;
            6'h01: return 8'h1D;
            6'h02: return 8'hF2;
            6'h08: return 8'((int'(s_x) / 16) % 256);
            6'h09: return 8'((int'(s_y) / 16) % 256);
            6'h0A: return 8'((int'(s_z) / 16) % 256);
            6'h0E, 6'h0F: v = signed_val(s_x);
            6'h10, 6'h11: v = signed_val(s_y);
            6'h12, 6'h13: v = signed_val(s_z);
            6'h2D: return m_power;
            default: return 8'h00;
        endcase
        if (a[0] == 1'b0) return 8'(v & 255);
        return 8'((v >>> 8) & 255);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_err === 1'b1) err_cycles++;
            if (pc_check) check("power_ctl monitor", 32'(power_ctl), 32'(m_power));
            if (miso_zero) check("miso idle", 32'(miso), 32'd0);
        end
    end

    task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit commit,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = miso;
            if (i == 0 && commit) pc_check = 1'b0;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i == 0 && commit) begin
                m_power  = tx;
                pc_check = 1'b1;
            end
            sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [7:0] adr, input int nbytes,
                        input int last_bits);
        logic [7:0] rx;
        logic [5:0] a;
        int bits;
        a = adr[5:0];
        cs = 1'b0;
        s_x = x_data;
        s_y = y_data;
        s_z = z_data;
        repeat (HALF) @(negedge clk);
        spi_byte(cmd, 8, 1'b0, rx);
        if (cmd != 8'h0B && cmd != 8'h0A) begin
            spi_byte(adr, 8, 1'b0, rx);
            spi_byte(8'hFF, 8, 1'b0, rx);
        end else begin
            spi_byte(adr, 8, 1'b0, rx);
            if (cmd == 8'h0B) miso_zero = 1'b0;
            for (int k = 0; k < nbytes; k++) begin
                bits = (k == nbytes - 1) ? last_bits : 8;
                if (cmd == 8'h0B) begin
                    spi_byte(8'h00, bits, 1'b0, rx);
                    rbuf[k] = rx;
                    if (bits == 8) check($sformatf("read[%02h]", a), 32'(rx), 32'(model_reg(a)));
                end else begin
                    spi_byte(wbuf[k], bits, (a == 6'h2D) && (bits == 8), rx);
                end
                if (bits == 8) a = a + 6'd1;
            end
        end
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (HALF) @(negedge clk);
        miso_zero = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rx;
        int err_before;

        repeat (2) @(negedge clk);
        check("reset miso", 32'(miso), 32'd0);
        check("reset cmd_err", 32'(cmd_err), 32'd0);
        check("reset power_ctl", 32'(power_ctl), 32'h00);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // ID burst
        xfer(8'h0B, 8'h00, 3, 8);
        check("id byte0", 32'(rbuf[0]), 32'hAD);
        check("id byte1", 32'(rbuf[1]), 32'h1D);
        check("id byte2", 32'(rbuf[2]), 32'hF2);

        // snapshot held while x_data changes mid-burst
        x_data = 12'h9A5;
        fork
            xfer(8'h0B, 8'h0E, 2, 8);
            begin
                repeat (300) @(negedge clk);
                x_data = 12'h123;
            end
        join
        check("snap xlo", 32'(rbuf[0]), 32'hA5);
        check("snap xhi", 32'(rbuf[1]), 32'hF9);

        // write then read back power_ctl
        wbuf[0] = 8'h02;
        xfer(8'h0A, 8'h2D, 1, 8);
        check("power_ctl after write", 32'(power_ctl), 32'h02);
        xfer(8'h0B, 8'h2D, 1, 8);
        check("readback 2D", 32'(rbuf[0]), 32'h02);

        // unsupported command
        err_before = err_cycles;
        xfer(8'h0F, 8'h2D, 0, 8);
        check("cmd_err pulse count", 32'(err_cycles - err_before), 32'd1);
        check("power_ctl after bad cmd", 32'(power_ctl), 32'h02);

        // partial write byte discarded
        wbuf[0] = 8'h55;
        xfer(8'h0A, 8'h2D, 1, 5);
        check("power_ctl after partial", 32'(power_ctl), 32'h02);
        xfer(8'h0B, 8'h00, 1, 8);
        check("read 00 after partial", 32'(rbuf[0]), 32'hAD);

        // full axis map
        x_data = 12'h9A5;
        y_data = 12'h47C;
        z_data = 12'hF01;
        xfer(8'h0B, 8'h08, 12, 8);
        check("map 08", 32'(rbuf[0]), 32'h9A);
        check("map 0A", 32'(rbuf[2]), 32'hF0);
        check("map 0F", 32'(rbuf[7]), 32'hF9);
        check("map 11", 32'(rbuf[9]), 32'h04);
        check("map 13", 32'(rbuf[11]), 32'hFF);

        // writes to read-only addresses discarded; burst write crossing 0x2D
        wbuf[0] = 8'h77;
        wbuf[1] = 8'h33;
        xfer(8'h0A, 8'h00, 2, 8);
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h08;
        xfer(8'h0A, 8'h2C, 2, 8);
        check("power_ctl burst write", 32'(power_ctl), 32'h08);
        xfer(8'h0B, 8'hC1, 1, 8);
        check("addr bits 7:6 ignored", 32'(rbuf[0]), 32'h1D);

        // wrap 3F -> 00, then reset in the middle of the second byte
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_byte(8'h0B, 8, 1'b0, rx);
        spi_byte(8'h3F, 8, 1'b0, rx);
        miso_zero = 1'b0;
        spi_byte(8'h00, 8, 1'b0, rx);
        check("wrap byte0", 32'(rx), 32'h00);
        spi_byte(8'h00, 5, 1'b0, rx);
        check("wrap byte1 bits", 32'(rx[7:3]), 32'h15);
        reset = 1'b1;
        m_power = 8'h00;
        #1;
        check("miso on reset", 32'(miso), 32'd0);
        check("power_ctl on reset", 32'(power_ctl), 32'h00);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        miso_zero = 1'b1;
        repeat (4) @(negedge clk);
        spi_byte(8'h0B, 8, 1'b0, rx);
        spi_byte(8'h00, 8, 1'b0, rx);
        spi_byte(8'h00, 8, 1'b0, rx);
        check("no response without fresh cs", 32'(rx), 32'h00);
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        xfer(8'h0B, 8'h00, 1, 8);
        check("read after reset", 32'(rbuf[0]), 32'hAD);

        check("total cmd_err cycles", 32'(err_cycles), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
